keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad and delivers debounced key codes to the processor side of the board top level. It is the input-side counterpart of the multiplexed seven-segment display driver. The display driver time-multiplexes outputs onto digit enables; this block time-multiplexes column drives and reads rows back. It sits between the keypad pins and the processor's input register.

## Interface
- SCAN_DIV, default 1000: clocks each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE, default 4: consecutive identical frames required to accept a press or a release; must be >= 1.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Row  input  4  keypad rows, active-low (pulled up externally); asynchronous to Clk.
- Col  output  4  keypad column drive, active-low, exactly one bit low at all times.
- KeyCode  output  4  code of the accepted key, Row index * 4 + Col index.
- KeyValid  output  1  one-cycle pulse when a new press is accepted.
- KeyHeld  output  1  high while the accepted key is still considered pressed.

## Operation
- Row passes through a 2-flop synchronizer before any use.
- Column counter cycles 0 -> 1 -> 2 -> 3 -> 0. Col = ~(1 << col), so reset gives 4'b1110.
- Dwell counter counts 0..SCAN_DIV-1 per column. Synchronized rows are sampled when dwell = SCAN_DIV-1, then the column advances.
- Per-column hit: exactly one synchronized row bit is low. A column with two or more rows low makes the frame invalid.
- Frame result is taken at the column-3 sample: {hit, code}.
  - Exactly one hit in the frame gives hit=1 and the code of that key.
  - Zero hits or an invalid frame gives hit=0.
- FSM states:
  - IDLE: on a hit frame, latch candidate code, set match count = 1, go to CONFIRM. If DEBOUNCE = 1, go directly to HELD.
  - CONFIRM: on a hit frame with the same code, increment count. At count = DEBOUNCE go to HELD. A frame with no hit or a different code returns to IDLE, and the count clears.
  - HELD: on entry, KeyCode <= candidate, KeyValid = 1 for one clock, KeyHeld = 1. A frame with no hit sets release count = 1 and goes to RELEASE. Any hit frame, including a different key, stays in HELD with no new pulse.
  - RELEASE: a no-hit frame increments the release count; at DEBOUNCE go to IDLE and drop KeyHeld. Any hit frame returns to HELD without a KeyValid pulse.
- KeyCode holds its last accepted value until the next accepted press. It never changes while KeyValid is low, except at reset.
- A second key pressed while one is held is ignored. A new press is accepted only after the release completes.

## Timing
- Reset values: Col = 4'b1110, KeyCode = 0, KeyValid = 0, KeyHeld = 0, FSM = IDLE, all counters 0, synchronizer flops = 4'b1111.
- Reset asserted mid-operation (any state) returns every output to its reset value asynchronously. No KeyValid pulse is produced for a press in progress.
- After Reset releases, the first column sample occurs at clock SCAN_DIV-1.
- Frame length = 4*SCAN_DIV clocks.
- Press latency from the first sampled frame containing the key: KeyValid rises the clock after the column-3 sample of the DEBOUNCE-th matching frame. KeyHeld rises in the same cycle as KeyValid.
- Release latency: KeyHeld falls the clock after the column-3 sample of the DEBOUNCE-th consecutive empty frame.
- Column settle: after a column change, at least SCAN_DIV-1 clocks elapse before the sample. This covers the 2-cycle synchronizer.

## Structure
- Package keypad_pkg holds:
  - the state enum (IDLE, CONFIRM, HELD, RELEASE);
  - NUM_ROWS = 4 and NUM_COLS = 4;
  - the Col reset constant 4'b1110.
- One sub-module, sync2: a parameterized-width 2-flop synchronizer with asynchronous active-low reset and a reset value of all ones. It is instantiated for Row.
- Scan counters, row decode, frame accumulation and the FSM live in keypad_scanner itself.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3 unless stated.
- Reset release with no keys pressed -> Col sequence 1110, 1101, 1011, 0111, each held 4 clocks. KeyValid is never asserted. KeyCode = 0.
- Row 2 pulled low whenever Col[1] is low, held for 5 frames -> exactly one KeyValid pulse with KeyCode = 9, one clock after the third frame end. KeyHeld is high from then on.
- Same key present in frame 1, absent in frame 2, present in frames 3-5 (bounce) -> KeyValid only after frame 5. There is exactly one pulse.
- Key 9 held, then released for 3 frames -> KeyHeld drops one clock after the third empty frame end. A release of only 2 frames followed by a re-press keeps KeyHeld high with no new pulse.
- Keys 0 and 5 pressed simultaneously -> no pulse. While key 9 is held, also pressing key 12 -> no new pulse, and KeyCode stays 9.
- Reset asserted during CONFIRM, 2 frames into a press of key 15 -> all outputs at reset values immediately. After release with the key still held, a pulse with KeyCode = 15 comes 3 full frames later.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    // One column driven low; column 0 is active out of reset.
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        StIdle,
        StConfirm,
        StHeld,
        StRelease
    } state_e;

    // Result of looking at the rows for one driven column.
    typedef struct packed {
        logic       hit;    // exactly one row low
        logic       multi;  // two or more rows low
        logic [1:0] idx;    // index of the low row when hit
    } row_dec_t;

    function automatic row_dec_t decode_rows(input logic [NUM_ROWS-1:0] rows);
        row_dec_t    dec;
        int unsigned n_low;
        dec   = '0;
        n_low = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) begin
                n_low   = n_low + 1;
                dec.idx = 2'(i);
            end
        end
        dec.hit   = (n_low == 1);
        dec.multi = (n_low > 1);
        return dec;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer, resets to all ones (idle level of pulled-up inputs).
module sync2 #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, frame decode and
// press/release debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_ROWS-1:0] Row,
    output logic [NUM_COLS-1:0] Col,
    output logic [3:0]          KeyCode,
    output logic                KeyValid,
    output logic                KeyHeld
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV);
    localparam int unsigned CntW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    logic [NUM_ROWS-1:0] row_sync;

    logic [DwellW-1:0]   dwell_q;
    logic [1:0]          col_q;
    logic [NUM_COLS-1:0] col_drv_q;
    logic [1:0]          frame_hits_q;
    logic [3:0]          frame_code_q;
    logic                frame_bad_q;

    state_e              state_q;
    logic [3:0]          cand_q;
    logic [CntW-1:0]     cnt_q;
    logic [3:0]          key_code_q;
    logic                key_valid_q;
    logic                key_held_q;

    row_dec_t            dec;
    logic                sample;
    logic [1:0]          col_next;
    logic [1:0]          hits_base;
    logic [1:0]          hits_new;
    logic [3:0]          code_new;
    logic                bad_new;
    logic                frame_done;
    logic                frame_hit;
    logic [CntW-1:0]     cnt_inc;
    logic                cnt_at_limit;

    sync2 #(
        .Width(NUM_ROWS)
    ) u_row_sync (
        .clk_i (Clk),
        .rst_ni(Reset),
        .d_i   (Row),
        .q_o   (row_sync)
    );

    // Fold the current column's rows into the frame; column 0 starts a new frame.
    always_comb begin
        dec          = decode_rows(row_sync);
        sample       = (dwell_q == DwellW'(SCAN_DIV - 1));
        col_next     = col_q + 2'd1;
        hits_base    = (col_q == 2'd0) ? 2'd0 : frame_hits_q;
        hits_new     = (hits_base == 2'd2) ? 2'd2 : hits_base + {1'b0, dec.hit};
        bad_new      = (col_q == 2'd0) ? dec.multi : (frame_bad_q | dec.multi);
        code_new     = dec.hit ? {dec.idx, col_q} : frame_code_q;
        frame_done   = sample && (col_q == 2'd3);
        frame_hit    = frame_done && (hits_new == 2'd1) && !bad_new;
        cnt_inc      = cnt_q + CntW'(1);
        cnt_at_limit = (cnt_inc == CntW'(DEBOUNCE));
    end

    // Dwell counter, column drive and per-frame accumulation.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dwell_q      <= '0;
            col_q        <= 2'd0;
            col_drv_q    <= COL_RESET;
            frame_hits_q <= 2'd0;
            frame_code_q <= 4'd0;
            frame_bad_q  <= 1'b0;
        end else if (sample) begin
            dwell_q      <= '0;
            col_q        <= col_next;
            col_drv_q    <= ~(4'b0001 << col_next);
            frame_hits_q <= hits_new;
            frame_code_q <= code_new;
            frame_bad_q  <= bad_new;
        end else begin
            dwell_q      <= dwell_q + DwellW'(1);
        end
    end

    // Debounce FSM, evaluated once per frame; outputs are registered.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_done) begin
                unique case (state_q)
                    StIdle: begin
                        if (frame_hit) begin
                            cand_q <= code_new;
                            if (DEBOUNCE == 1) begin
                                state_q     <= StHeld;
                                cnt_q       <= '0;
                                key_code_q  <= code_new;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                state_q <= StConfirm;
                                cnt_q   <= CntW'(1);
                            end
                        end
                    end
                    StConfirm: begin
                        if (frame_hit && (code_new == cand_q)) begin
                            if (cnt_at_limit) begin
                                state_q     <= StHeld;
                                cnt_q       <= '0;
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end
                    end
                    StHeld: begin
                        if (!frame_hit) begin
                            if (DEBOUNCE == 1) begin
                                state_q    <= StIdle;
                                cnt_q      <= '0;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q <= StRelease;
                                cnt_q   <= CntW'(1);
                            end
                        end
                    end
                    StRelease: begin
                        if (frame_hit) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else if (cnt_at_limit) begin
                            state_q    <= StIdle;
                            cnt_q      <= '0;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign Col      = col_drv_q;
    assign KeyCode  = key_code_q;
    assign KeyValid = key_valid_q;
    assign KeyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, press scoreboard, column checks.
module tb_keypad_scanner;

    localparam int unsigned SD    = 4;
    localparam int unsigned DB    = 3;
    localparam int unsigned FRAME = 4 * SD;

    typedef struct {
        int unsigned code;
        int unsigned cyc;
    } exp_t;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [3:0]  KeyCode;
    logic        KeyValid;
    logic        KeyHeld;

    logic [15:0] pressed = '0;
    int unsigned cyc;
    int unsigned fr;
    int unsigned fall_cyc = 0;
    int unsigned rel_base;
    logic        held_prev = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        exp_q[$];

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Row     (Row),
        .Col     (Col),
        .KeyCode (KeyCode),
        .KeyValid(KeyValid),
        .KeyHeld (KeyHeld)
    );

    always #5 Clk = ~Clk;

    // Passive keypad: a pressed key connects its row to its (low) column.
    always @* begin
        logic [3:0] r_v;
        r_v = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !Col[c]) r_v[r] = 1'b0;
        Row = r_v;
    end

    // Clocks since reset release.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic frames(input int unsigned n);
        repeat (n * FRAME) @(posedge Clk);
        #1;
        fr += n;
    endtask

    task automatic expect_press(input int unsigned code, input int unsigned frame);
        exp_t e;
        e.code = code;
        e.cyc  = frame * FRAME;
        exp_q.push_back(e);
    endtask

    // Column sequence, scoreboard for KeyValid pulses, release timing.
    always @(negedge Clk) begin
        logic [3:0] col_exp;
        exp_t       e;
        if (!Reset) begin
            check("col_in_reset", Col, 4'b1110);
        end else begin
            col_exp = 4'b1111;
            col_exp[(cyc / SD) % 4] = 1'b0;
            check("col_seq", Col, col_exp);
            if (KeyValid) begin
                check("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("valid_code", KeyCode, e.code);
                    check("valid_cycle", cyc, e.cyc);
                    check("held_with_valid", KeyHeld, 1);
                end
            end
            if (held_prev && !KeyHeld) fall_cyc = cyc;
        end
        held_prev = KeyHeld;
    end

    initial begin
        // Reset state
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_code", KeyCode, 0);
        check("rst_valid", KeyValid, 0);
        check("rst_held", KeyHeld, 0);
        check("rst_col", Col, 4'b1110);
        @(negedge Clk);
        Reset = 1'b1;
        fr = 0;

        // Idle scanning, no keys
        frames(2);
        check("idle_code", KeyCode, 0);
        check("idle_held", KeyHeld, 0);

        // Clean press of key 9 (row 2, col 1)
        pressed[9] = 1'b1;
        expect_press(9, fr + DB);
        frames(5);
        check("press9_held", KeyHeld, 1);
        check("press9_code", KeyCode, 9);

        // Short release then re-press: no new pulse, held stays up
        pressed[9] = 1'b0;
        frames(2);
        check("short_rel_held", KeyHeld, 1);
        pressed[9] = 1'b1;
        frames(2);
        check("repress_held", KeyHeld, 1);

        // Full release
        pressed[9] = 1'b0;
        rel_base = fr;
        frames(4);
        check("release_held", KeyHeld, 0);
        check("release_fall_cycle", fall_cyc, (rel_base + DB) * FRAME);
        check("release_code", KeyCode, 9);

        // Bounce: present, absent, then present for three frames
        pressed[9] = 1'b1;
        expect_press(9, fr + 5);
        frames(1);
        pressed[9] = 1'b0;
        frames(1);
        pressed[9] = 1'b1;
        frames(3);
        check("bounce_held", KeyHeld, 1);
        pressed[9] = 1'b0;
        frames(4);
        check("bounce_rel_held", KeyHeld, 0);

        // Two keys in different columns: no acceptance
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        frames(4);
        check("multi_held", KeyHeld, 0);
        check("multi_code", KeyCode, 9);
        pressed = '0;

        // Key 12 added while 9 is held: no pulse, code unchanged
        pressed[9] = 1'b1;
        expect_press(9, fr + DB);
        frames(4);
        pressed[12] = 1'b1;
        frames(2);
        check("second_key_held", KeyHeld, 1);
        check("second_key_code", KeyCode, 9);
        pressed[12] = 1'b0;
        frames(2);
        check("second_rel_held", KeyHeld, 1);
        pressed[9] = 1'b0;
        frames(4);
        check("second_final_held", KeyHeld, 0);

        // Reset during confirmation of key 15
        pressed[15] = 1'b1;
        frames(2);
        #3;
        Reset = 1'b0;
        #1;
        check("midrst_code", KeyCode, 0);
        check("midrst_valid", KeyValid, 0);
        check("midrst_held", KeyHeld, 0);
        check("midrst_col", Col, 4'b1110);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        fr = 0;
        expect_press(15, DB);
        frames(4);
        check("post_rst_held", KeyHeld, 1);
        check("post_rst_code", KeyCode, 15);
        pressed = '0;
        frames(1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
